pipe_control: RTL
=================

# pipe_control

Parametrised pipelined control unit for the five-stage RV32I(+M) core. It decodes the ID-stage opcode into control bundles and carries them through ID/EX, EX/MEM and MEM/WB registers. It also generates the pipeline stall for load-use hazards and multi-cycle multiply/divide occupancy, and inserts bubbles on stall or flush. It replaces the combinational decoder plus external NoOp muxing and the separate hazard unit.

## Interface
Parameters:
- ALUOP_W, 2, width of ALU-op field; encodings are the shared ALU_OP_* constants from Const.v
- REG_ADDR_W, 5, register-index width
- MULDIV_LAT, 4, EX-stage cycles occupied by an M-extension op (≥1; 1 = no extra stall)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  IF/ID holds a real instruction
- opcode_i  in  7  ID instruction [6:0]
- funct7_i  in  7  ID instruction [31:25]
- rs1_i, rs2_i, rd_i  in  REG_ADDR_W  ID register indices
- flush_i  in  1  kill the ID instruction (taken branch resolved in EX)
- stall_o  out  1  hold PC and IF/ID (combinational)
- busy_o  out  1  multi-cycle op occupying EX
- ex_aluop_o  out  ALUOP_W; ex_alusrc_o, ex_branch_o, ex_muldiv_o, ex_illegal_o  out  1  ID/EX bundle
- mem_memread_o, mem_memwrite_o  out  1  EX/MEM bundle
- wb_regwrite_o, wb_memtoreg_o  out  1; wb_rd_o  out  REG_ADDR_W  MEM/WB bundle

## Operation
- Decode (combinational, ID). Fields are alusrc, regwrite, memtoreg, memread, memwrite, branch:
  - 0110011 R: ALU_OP_REG, 0,1,0,0,0,0. If funct7=0000001, muldiv=1.
  - 0010011 I-arith: ALU_OP_IMM, 1,1,0,0,0,0.
  - 0000011 load: ALU_OP_IMM, 1,1,1,1,0,0.
  - 0100011 store: ALU_OP_STORE, 1,0,0,0,1,0.
  - 1100011 branch: ALU_OP_BRANCH, 0,0,0,0,0,1.
  - Any other opcode with valid_i=1: all fields 0, illegal=1.
  - valid_i=0: bubble. Every field is defined for every opcode; there are no don't-cares.
- Bubble is all-zero control with rd=0.
- The rd field is zeroed whenever regwrite=0.
- Load-use hazard: ID/EX memread=1, ID/EX rd≠0, and ID/EX rd matches a used source.
  - rs1 is used by R, I, load, store and branch.
  - rs2 is used by R, store and branch.
- Busy counter: loaded with MULDIV_LAT-1 when a muldiv bundle enters ID/EX. It decrements each cycle while nonzero. busy_o = (counter≠0).
- Per-cycle update, priority high→low:
  1. rst_i: all pipeline registers and counter ← 0.
  2. busy_o: ID/EX holds; EX/MEM ← bubble; MEM/WB advances; stall_o=1. flush_i is ignored while busy.
  3. flush_i: ID/EX ← bubble; others advance; stall_o=0.
  4. Load-use: ID/EX ← bubble; others advance; stall_o=1.
  5. Otherwise all stages advance; ID/EX ← decoded bundle.
- EX/MEM always takes memread, memwrite, regwrite, memtoreg and rd from ID/EX.
- MEM/WB always takes regwrite, memtoreg and rd from EX/MEM.

## Timing
- Reset values: every output is 0, including stall_o and busy_o.
- Decode→ex_* outputs: 1 cycle. mem_*: 2 cycles. wb_*: 3 cycles.
- stall_o is combinational from registered state and ID inputs, valid in the same cycle.
- Load-use stall lasts exactly 1 cycle.
- A muldiv at ID/EX holds for MULDIV_LAT cycles total, asserting MULDIV_LAT-1 stall cycles. It enters EX/MEM on the cycle after the counter reaches 0.
- Back-to-back muldiv: the second op enters ID/EX on the release cycle and reloads the counter.
- A muldiv writing rd followed by a dependent op needs no extra stall; forwarding is handled externally.
- Reset asserted mid-stall: pipeline is cleared and the counter is 0 on the next cycle.

## Test plan
- Reset: rst_i=1 for 2 cycles with random inputs → all outputs 0. After release, first R-type add yields ex_aluop_o=ALU_OP_REG at +1, wb_regwrite_o=1 at +3.
- Load-use: lw x5 then add x6,x5,x1 → stall_o=1 for exactly 1 cycle; ex_* shows a bubble; add reaches ID/EX one cycle later. Repeating with rd=x0 gives no stall.
- Muldiv, MULDIV_LAT=4: mul x3,x1,x2 → busy_o high 3 cycles, stall_o high 3 cycles, 3 EX/MEM bubbles, mul reaches mem stage 4 cycles after entering EX.
- Same test with MULDIV_LAT=1 → no stall, no busy.
- Flush: flush_i=1 with a store in ID → ex_* all 0; mem_memwrite_o never asserts.
- flush_i together with a load-use hazard → flush wins; stall_o=0.
- Illegal opcode 1111111 → ex_illegal_o=1 for one cycle; no write or memory strobe downstream.
- Store after load on rs2: lw x7 then sw x7,0(x2) → 1-cycle stall.
- Branch with rs2 match → 1-cycle stall.
- I-type with an rs2 field match only → no stall.

Source files
------------

// File: rtl/pipe_control.sv
// Pipelined control for the five-stage RV32I(+M) core: ID decode, ID/EX, EX/MEM and MEM/WB
// control registers, load-use and multiply/divide stall generation, and bubble insertion.
module pipe_control #(
    parameter int ALUOP_W    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [6:0]            opcode_i,
    input  logic [6:0]            funct7_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic [ALUOP_W-1:0]    ex_aluop_o,
    output logic                  ex_alusrc_o,
    output logic                  ex_branch_o,
    output logic                  ex_muldiv_o,
    output logic                  ex_illegal_o,
    output logic                  mem_memread_o,
    output logic                  mem_memwrite_o,
    output logic                  wb_regwrite_o,
    output logic                  wb_memtoreg_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [ALUOP_W-1:0] ALU_OP_STORE  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_OP_BRANCH = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_OP_REG    = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OP_IMM    = ALUOP_W'(3);

    localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    typedef struct packed {
        logic [ALUOP_W-1:0]    aluop;
        logic                  alusrc;
        logic                  regwrite;
        logic                  memtoreg;
        logic                  memread;
        logic                  memwrite;
        logic                  branch;
        logic                  muldiv;
        logic                  illegal;
        logic [REG_ADDR_W-1:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic                  memread;
        logic                  memwrite;
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
    } wb_ctrl_t;

    ex_ctrl_t  dec, id_ex;
    mem_ctrl_t ex_mem;
    wb_ctrl_t  mem_wb;
    logic [CNT_W-1:0] cnt;
    logic use_rs1, use_rs2, load_use, busy;

    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (valid_i) begin
            case (opcode_i)
                OP_R: begin
                    dec.aluop    = ALU_OP_REG;
                    dec.regwrite = 1'b1;
                    dec.muldiv   = (funct7_i == F7_MULDIV);
                    use_rs1      = 1'b1;
                    use_rs2      = 1'b1;
                end
                OP_IMM: begin
                    dec.aluop    = ALU_OP_IMM;
                    dec.alusrc   = 1'b1;
                    dec.regwrite = 1'b1;
                    use_rs1      = 1'b1;
                end
                OP_LOAD: begin
                    dec.aluop    = ALU_OP_IMM;
                    dec.alusrc   = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.memtoreg = 1'b1;
                    dec.memread  = 1'b1;
                    use_rs1      = 1'b1;
                end
                OP_STORE: begin
                    dec.aluop    = ALU_OP_STORE;
                    dec.alusrc   = 1'b1;
                    dec.memwrite = 1'b1;
                    use_rs1      = 1'b1;
                    use_rs2      = 1'b1;
                end
                OP_BRANCH: begin
                    dec.aluop  = ALU_OP_BRANCH;
                    dec.branch = 1'b1;
                    use_rs1    = 1'b1;
                    use_rs2    = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        // Non-writing ops carry rd=0 so downstream hazard/forwarding logic never matches them.
        dec.rd = dec.regwrite ? rd_i : '0;
    end

    assign load_use = id_ex.memread && (id_ex.rd != '0) &&
                      ((use_rs1 && (rs1_i == id_ex.rd)) || (use_rs2 && (rs2_i == id_ex.rd)));
    assign busy     = (cnt != '0);
    assign stall_o  = busy || (!flush_i && load_use);
    assign busy_o   = busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
            cnt    <= '0;
        end else begin
            mem_wb <= '{regwrite: ex_mem.regwrite, memtoreg: ex_mem.memtoreg, rd: ex_mem.rd};
            if (busy) begin
                // Multi-cycle op parks in EX; flush is deliberately ignored here.
                ex_mem <= '0;
                cnt    <= cnt - CNT_W'(1);
            end else begin
                ex_mem <= '{memread: id_ex.memread, memwrite: id_ex.memwrite,
                            regwrite: id_ex.regwrite, memtoreg: id_ex.memtoreg, rd: id_ex.rd};
                if (flush_i || load_use) begin
                    id_ex <= '0;
                end else begin
                    id_ex <= dec;
                    if (dec.muldiv) cnt <= CNT_LOAD;
                end
            end
        end
    end

    assign ex_aluop_o     = id_ex.aluop;
    assign ex_alusrc_o    = id_ex.alusrc;
    assign ex_branch_o    = id_ex.branch;
    assign ex_muldiv_o    = id_ex.muldiv;
    assign ex_illegal_o   = id_ex.illegal;
    assign mem_memread_o  = ex_mem.memread;
    assign mem_memwrite_o = ex_mem.memwrite;
    assign wb_regwrite_o  = mem_wb.regwrite;
    assign wb_memtoreg_o  = mem_wb.memtoreg;
    assign wb_rd_o        = mem_wb.rd;

endmodule
